// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// SRAM-like request/response channel; the master issues requests, the slave answers.
interface mem_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata,
                    input  rdata, addr_ok, data_ok);

    modport slave  (input  req, wr, size, addr, wdata,
                    output rdata, addr_ok, data_ok);
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and memory-stage requesters onto one SRAM-like bus,
// one outstanding transaction at a time, data side winning ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  inst,
    mem_arbiter_if.slave  data,
    mem_arbiter_if.master bus,
    output logic          stallreq_from_if,
    output logic          stallreq_from_mem
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic addr_ok_pulse;
    logic data_ok_pulse;
    logic inst_addr_ok, inst_data_ok;
    logic data_addr_ok, data_data_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        addr_ok_pulse = 1'b0;
        data_ok_pulse = 1'b0;
        bus.req       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data.req) begin
                    owner_d = OWN_DATA;
                    wr_d    = data.wr;
                    size_d  = data.size;
                    addr_d  = data.addr;
                    wdata_d = data.wdata;
                    state_d = ST_ADDR;
                end else if (inst.req) begin
                    owner_d = OWN_INST;
                    wr_d    = 1'b0;
                    size_d  = SIZE_WORD;
                    addr_d  = inst.addr;
                    wdata_d = 32'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus.req = 1'b1;
                // A data_ok without addr_ok here belongs to nothing we issued.
                if (bus.addr_ok) begin
                    addr_ok_pulse = 1'b1;
                    if (bus.data_ok) begin
                        data_ok_pulse = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.data_ok) begin
                    data_ok_pulse = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = addr_ok_pulse && (owner_q == OWN_INST);
        inst_data_ok = data_ok_pulse && (owner_q == OWN_INST);
        data_addr_ok = addr_ok_pulse && (owner_q == OWN_DATA);
        data_data_ok = data_ok_pulse && (owner_q == OWN_DATA);

        inst_rdata_d = inst_data_ok ? bus.rdata : inst_rdata_q;
        data_rdata_d = data_data_ok ? bus.rdata : data_rdata_q;

        inst.addr_ok = inst_addr_ok;
        inst.data_ok = inst_data_ok;
        inst.rdata   = inst_rdata_d;
        data.addr_ok = data_addr_ok;
        data.data_ok = data_data_ok;
        data.rdata   = data_rdata_d;

        bus.wr    = wr_q;
        bus.size  = size_q;
        bus.addr  = addr_q;
        bus.wdata = wdata_q;

        stallreq_from_if  = inst.req && !inst_data_ok;
        stallreq_from_mem = data.req && !data_data_ok;
    end

endmodule
